// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH bits per frame strobe, MSB- or LSB-first,
// and presents the assembled word with a one-cycle valid pulse or an early-end error pulse.
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             serial_i,
    input  logic             frame_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             dbg_state_o
);

    // Output handshake: valid_o is a one-cycle push with no backpressure; data_o is
    // updated on the same edge and held until the next word completes.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sr;
    logic             order;
    logic             cap_dir;
    logic [WIDTH-1:0] sr_next;

    // The first bit of a word uses the live dir_i; later bits use the latched order.
    always_comb begin
        cap_dir = (state == IDLE) ? dir_i : order;
        sr_next = sr;
        if (cap_dir) begin
            sr_next = {serial_i, sr[WIDTH-1:1]};
        end else begin
            sr_next = {sr[WIDTH-2:0], serial_i};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            count   <= '0;
            sr      <= '0;
            order   <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_i) begin
                        order  <= dir_i;
                        sr     <= sr_next;
                        count  <= CW'(1);
                        state  <= SHIFT;
                        busy_o <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (frame_i) begin
                        sr <= sr_next;
                        if (count == LAST) begin
                            data_o  <= sr_next;
                            valid_o <= 1'b1;
                            count   <= '0;
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end else begin
                        err_o  <= 1'b1;
                        count  <= '0;
                        sr     <= '0;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    count  <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state_o = (state == SHIFT);

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: drives framed serial words and scores the parallel
// output, valid/err pulse timing and busy against a queue-based model.
module tb_serial_deserializer;

    localparam int WIDTH = 8;

    logic             Clk;
    logic             Rst;
    logic             serial_i;
    logic             frame_i;
    logic             dir_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             busy_o;
    logic             err_o;
    logic             dbg_state_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic run       = 1'b0;
    logic exp_busy  = 1'b0;
    logic [WIDTH-1:0] last_word = '0;

    logic [WIDTH-1:0] exp_q[$];
    int               cyc_q[$];
    int               err_q[$];

    serial_deserializer #(.WIDTH(WIDTH)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .serial_i    (serial_i),
        .frame_i     (frame_i),
        .dir_i       (dir_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // Sends nbits of stream, first-sent bit = stream[WIDTH-1]. dir_i flips from bit
    // index sw onward (sw < 0 means never) to show the latched order wins.
    task automatic send_frame(input logic [WIDTH-1:0] stream, input logic d, input int nbits,
                              input int sw);
        for (int i = 0; i < nbits; i++) begin
            @(negedge Clk);
            serial_i = stream[WIDTH-1-i];
            frame_i  = 1'b1;
            dir_i    = (sw >= 0 && i >= sw) ? ~d : d;
            exp_busy = (i != WIDTH - 1);
            if (i == WIDTH - 1) begin
                last_word = d ? rev(stream) : stream;
                exp_q.push_back(last_word);
                cyc_q.push_back(cyc + 1);
            end
        end
    endtask

    task automatic end_frame(input logic expect_err, input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) begin
            @(negedge Clk);
            frame_i  = 1'b0;
            serial_i = 1'($urandom_range(0, 1));
            dir_i    = 1'($urandom_range(0, 1));
            exp_busy = 1'b0;
            if (i == 0 && expect_err) err_q.push_back(cyc + 1);
        end
    endtask

    // scoreboard / monitor
    always @(posedge Clk) begin
        #1;
        if (run && !Rst) begin
            check("busy", busy_o, exp_busy);
            check("dbg_state", dbg_state_o, exp_busy);
            check("valid_err_excl", valid_o & err_o, 1'b0);
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", 1'b1, 1'b0);
                end else begin
                    check("data", data_o, exp_q.pop_front());
                    check("valid_cycle", cyc, cyc_q.pop_front());
                end
            end else if (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
                check("valid_missing", 1'b0, 1'b1);
                void'(cyc_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (err_o) begin
                if (err_q.size() == 0) check("err_unexpected", 1'b1, 1'b0);
                else check("err_cycle", cyc, err_q.pop_front());
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                check("err_missing", 1'b0, 1'b1);
                void'(err_q.pop_front());
            end
        end
    end

    // stimulus
    initial begin
        Rst      = 1'b1;
        serial_i = 1'b0;
        frame_i  = 1'b0;
        dir_i    = 1'b0;
        #2;
        check("rst_data", data_o, '0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        run = 1'b1;
        end_frame(1'b0, 2);

        // MSB-first and LSB-first on the same stream
        send_frame(8'h23, 1'b0, 8, -1);
        end_frame(1'b0, 3);
        check("msb_word", data_o, 8'h23);
        send_frame(8'h23, 1'b1, 8, -1);
        end_frame(1'b0, 3);
        check("lsb_word", data_o, 8'hC4);

        // back-to-back words, 16 continuous frame cycles
        send_frame(8'hA5, 1'b0, 8, -1);
        send_frame(8'h5A, 1'b0, 8, -1);
        end_frame(1'b0, 3);

        // early end after a completed word
        send_frame(8'hA5, 1'b0, 8, -1);
        send_frame(8'hFF, 1'b0, 5, -1);
        end_frame(1'b1, 4);
        check("hold_after_err", data_o, 8'hA5);

        // direction change mid-word is ignored
        send_frame(8'h23, 1'b0, 8, 3);
        end_frame(1'b0, 3);
        check("dir_latched", data_o, 8'h23);

        // asynchronous reset mid-word
        send_frame(8'hC3, 1'b0, 4, -1);
        @(negedge Clk);
        frame_i = 1'b0;
        #1 Rst = 1'b1;
        exp_busy = 1'b0;
        last_word = '0;
        #1;
        check("mid_rst_data", data_o, '0);
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_err", err_o, 1'b0);
        #1 Rst = 1'b0;
        end_frame(1'b0, 2);
        send_frame(8'h3C, 1'b0, 8, -1);
        end_frame(1'b0, 3);
        check("post_rst_word", data_o, 8'h3C);

        // random words, random order, occasional gaps and truncations
        for (int k = 0; k < 10; k++) begin
            logic [WIDTH-1:0] w;
            logic             d;
            int               n;
            w = WIDTH'($urandom_range(0, 255));
            d = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WIDTH - 1) : WIDTH;
            send_frame(w, d, n, -1);
            if (n < WIDTH) end_frame(1'b1, 2);
            else if ($urandom_range(0, 1) == 1) end_frame(1'b0, $urandom_range(1, 3));
        end
        end_frame(1'b0, 4);
        check("last_word", data_o, last_word);

        check("valid_q_empty", exp_q.size(), 0);
        check("err_q_empty", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
